// File: rtl/scpu_cmd_mailbox.sv
// scpu_cmd_mailbox: main-CPU to sound-CPU command FIFO with status port and edge-friendly interrupt pulses
// Ports:
//   clk_sys, reset_n         clock, asynchronous active-low reset
//   mcpu_cmd_wr/din/full     main-CPU push strobe, command byte, FIFO full
//   scpu_ab/io/rd/m1         sound-CPU address low byte and bus strobes
//   scpu_dout                combinational read data (8'hFF when nothing decodes)
//   scpu_int                 registered interrupt pulse, always a fresh rising edge
module scpu_cmd_mailbox #(
  parameter int         FIFO_AW   = 2,
  parameter int         TIMER_DIV = 262144,
  parameter int         INT_HOLD  = 16,
  parameter int         INT_GAP   = 16,
  parameter logic [7:0] CMD_PORT  = 8'h00,
  parameter logic [7:0] STAT_PORT = 8'h01
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       mcpu_cmd_wr,
  input  logic [7:0] mcpu_cmd_din,
  output logic       mcpu_cmd_full,
  input  logic [7:0] scpu_ab,
  input  logic       scpu_io,
  input  logic       scpu_rd,
  input  logic       scpu_m1,
  output logic [7:0] scpu_dout,
  output logic       scpu_int
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TW    = $clog2(TIMER_DIV);
  localparam int HW    = $clog2(INT_HOLD > INT_GAP ? INT_HOLD : INT_GAP) + 1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] rptr, wptr;
  logic [CW-1:0]      count;
  logic [TW-1:0]      tcnt;
  logic [HW-1:0]      icnt;
  state_t             state;
  logic               timer_flag, overflow, irq_req, rd_cmd_q, rd_stat_q;
  logic               rd_cmd, rd_stat, cmd_fall, stat_fall;
  logic               empty, full, pop, push, wrap, irq_set;
  logic [2:0]         cnt_sat;

  assign rd_cmd    = scpu_io & scpu_rd & ~scpu_m1 & (scpu_ab == CMD_PORT);
  assign rd_stat   = scpu_io & scpu_rd & ~scpu_m1 & (scpu_ab == STAT_PORT);
  // read side effects wait for the end of the strobe so data stays stable while it is latched
  assign cmd_fall  = rd_cmd_q & ~rd_cmd;
  assign stat_fall = rd_stat_q & ~rd_stat;
  assign empty     = count == '0;
  assign full      = count == CW'(DEPTH);
  assign pop       = cmd_fall & ~empty;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign push      = mcpu_cmd_wr & (~full | pop);
  assign wrap      = tcnt == TW'(TIMER_DIV - 1);
  assign irq_set   = (push & empty) | (pop & ((count > CW'(1)) | push)) | wrap;

  always_comb cnt_sat = (32'(count) > 7) ? 3'd7 : 3'(count);

  assign scpu_dout     = rd_cmd  ? (empty ? 8'hFF : mem[rptr]) :
                         rd_stat ? {timer_flag, overflow, full, empty, 1'b0, cnt_sat} : 8'hFF;
  assign mcpu_cmd_full = full;

  always_ff @(posedge clk_sys)
    if (push) mem[wptr] <= mcpu_cmd_din;

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      tcnt       <= '0;
      timer_flag <= 1'b0;
      overflow   <= 1'b0;
      rd_cmd_q   <= 1'b0;
      rd_stat_q  <= 1'b0;
    end else begin
      rd_cmd_q   <= rd_cmd;
      rd_stat_q  <= rd_stat;
      rptr       <= pop ? rptr + 1'b1 : rptr;
      wptr       <= push ? wptr + 1'b1 : wptr;
      count      <= count + CW'(push) - CW'(pop);
      tcnt       <= wrap ? '0 : tcnt + 1'b1;
      // a wrap coinciding with the status-read clear keeps the flag set
      timer_flag <= wrap | (timer_flag & ~stat_fall);
      overflow   <= (mcpu_cmd_wr & full & ~pop) | (overflow & ~stat_fall);
    end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      icnt     <= '0;
      irq_req  <= 1'b0;
      scpu_int <= 1'b0;
    end else begin
      // requests during HIGH/GAP stay latched and merge into a single follow-up pulse
      irq_req <= irq_set | (irq_req & (state != IDLE));
      case (state)
        IDLE: if (irq_req) begin
          state    <= HIGH;
          scpu_int <= 1'b1;
          icnt     <= '0;
        end
        HIGH: if (icnt == HW'(INT_HOLD - 1)) begin
          state    <= GAP;
          scpu_int <= 1'b0;
          icnt     <= '0;
        end else icnt <= icnt + 1'b1;
        GAP: if (icnt == HW'(INT_GAP - 1)) state <= IDLE;
             else icnt <= icnt + 1'b1;
        default: begin
          state    <= IDLE;
          scpu_int <= 1'b0;
        end
      endcase
    end
endmodule
